simcomp_mem_arbiter: RTL and testbench
======================================

Name: simcomp_mem_arbiter

Overview:
- Two-port round-robin arbiter and owner of the single-port 64x16 simple-computer memory.
- Port 0 is the CPU fetch/operand/store path. Port 1 is a program loader / debug requester.
- Serialises all memory accesses so the two requesters never touch the array in the same cycle.
- Sits between the simcomp core and the memory array; replaces direct array indexing by the core.

Parameters:
- DW, 16, memory word width
- AW, 6, address width; depth is 2**AW = 64 words

Ports:
- clk      input   1    system clock; all state changes on rising edge
- rst      input   1    asynchronous, active-high reset
- req0     input   1    port 0 request; held high with we0/addr0/wdata0 stable until ack0
- we0      input   1    port 0: 1 = write, 0 = read
- addr0    input   AW   port 0 word address
- wdata0   input   DW   port 0 write data
- ack0     output  1    port 0 completion; one-cycle pulse
- rdata0   output  DW   port 0 read data; valid while ack0 is high, then held
- req1     input   1    port 1 request; same rules as port 0
- we1      input   1    port 1: 1 = write, 0 = read
- addr1    input   AW   port 1 word address
- wdata1   input   DW   port 1 write data
- ack1     output  1    port 1 completion; one-cycle pulse
- rdata1   output  DW   port 1 read data; valid while ack1 is high, then held
- busy     output  1    high while the FSM is in ACCESS
- gnt_id   output  1    port currently or last granted

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; ack0=ack1=0; rdata0=rdata1=0; busy=0; gnt_id=0.
  - last_gnt=1, so port 0 wins the first tie.
  - Memory contents are not cleared.
- FSM has two states, IDLE and ACCESS.
- IDLE, at a rising edge:
  - eligible_N = reqN & ~ackN. A port whose ack is high this cycle is excluded from this arbitration.
  - No eligible port: stay in IDLE.
  - One eligible port: grant it.
  - Both eligible: grant the port != last_gnt.
  - On grant: latch we/addr/wdata of the winner; gnt_id <= winner; last_gnt <= winner; busy <= 1; go to ACCESS.
- ACCESS, at a rising edge:
  - Write: mem[addr] <= wdata.
  - Read: rdata_winner <= mem[addr].
  - ack_winner <= 1 for exactly one cycle; busy <= 0; go to IDLE.
- Latency: request sampled at edge E0 → memory operation and ack at edge E1 → ack visible in the cycle after E1.
  - Throughput: at most one access per 2 cycles.
  - Fully alternating back-to-back service when both ports hold req.
- Ack rules:
  - ack is registered, and only the granted port's ack is ever high.
  - ack0 and ack1 are never high in the same cycle.
- Requester rules:
  - A requester must drop req, or present its next transaction, in the cycle after ack.
  - Holding req continuously issues a new transaction per grant.
- rdata: updated only on reads; writes leave it unchanged.
- Ordering: a write followed by a read of the same address returns the new data.
- Requests to the full address range 0..63 are legal; there is no out-of-range case at AW=6.
- Inputs changing while a request is pending but not yet granted: the values sampled at the grant edge are used.
- Reset asserted during ACCESS:
  - The access is aborted; no memory write occurs.
  - No ack is produced; the FSM returns to IDLE.
  - The requester must re-issue the transaction after reset.

Test Plan:
- Reset: hold rst high for 3 cycles with req0=req1=1 → ack0=ack1=0, rdata0=rdata1=0, busy=0, no memory change.
- Single port: port 0 writes 16'h3020 to addr 10, then reads addr 10 → ack0 in the 2nd cycle after each request edge; read returns rdata0=16'h3020; busy high exactly 1 cycle per access.
- Tie after reset: req0 and req1 both reads of addr 20 (=9) and addr 21 (=4) → port 0 granted first (gnt_id=0, rdata0=9); port 1 acked 2 cycles later (rdata1=4); acks never overlap.
- Fairness: both ports hold req for 6 transactions → grant order 0,1,0,1,0,1; one ack every 2 cycles.
- Abort: mem[23]=0; port 1 writes 16'hBEEF to addr 23; pulse rst during ACCESS → no ack1; subsequent port 0 read of addr 23 returns 16'h0000.
- Boundaries: port 1 writes 16'hFFFF to addr 63 while port 0 writes 16'h0001 to addr 0, then both read back → rdata1=16'hFFFF, rdata0=16'h0001; no aliasing between addr 0 and 63.

Source files
------------

// File: rtl/simcomp_mem_arbiter.sv
// simcomp_mem_arbiter: two-port round-robin arbiter that owns the 64x16
// single-port memory of the simple computer. Port 0 is the CPU path, port 1
// the loader/debug path. One access every two cycles at most.
module simcomp_mem_arbiter #(
  parameter int DW = 16,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          gnt_id
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          last_gnt;
  logic          elig0;
  logic          elig1;
  logic          grant;
  logic          winner;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [DW-1:0] mem [DEPTH];

  // Arbitration and next-state: a port whose ack is showing this cycle sits
  // out, which yields strict alternation when both ports hold req.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    winner     = 1'b0;
    elig0      = req0 & ~ack0;
    elig1      = req1 & ~ack1;
    case (state)
      IDLE: begin
        if (elig0 | elig1) begin
          grant      = 1'b1;
          winner     = (elig0 & elig1) ? ~last_gnt : elig1;
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Grant latching, registered acks and read data; last_gnt resets to 1 so
  // port 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt  <= 1'b1;
      gnt_id    <= 1'b0;
      busy      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (grant) begin
        gnt_id    <= winner;
        last_gnt  <= winner;
        busy      <= 1'b1;
        lat_we    <= winner ? we1    : we0;
        lat_addr  <= winner ? addr1  : addr0;
        lat_wdata <= winner ? wdata1 : wdata0;
      end
      if (state == ACCESS) begin
        busy <= 1'b0;
        if (gnt_id) begin
          ack1 <= 1'b1;
          if (!lat_we) rdata1 <= mem[lat_addr];
        end else begin
          ack0 <= 1'b1;
          if (!lat_we) rdata0 <= mem[lat_addr];
        end
      end
    end
  end

  // Memory array write port; contents survive reset, and a reset landing on
  // an ACCESS cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (state == ACCESS && lat_we && !rst) mem[lat_addr] <= lat_wdata;
  end

endmodule

// File: tb/tb_simcomp_mem_arbiter.sv
// tb_simcomp_mem_arbiter: directed self-checking bench for the two-port
// memory arbiter. Inputs are driven and outputs sampled on falling edges.
module tb_simcomp_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [5:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, busy, gnt_id;
  logic [15:0] rdata0, rdata1;

  int n_cmp = 0;
  int n_bad = 0;

  simcomp_mem_arbiter #(.DW(16), .AW(6)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1),
    .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single-port transaction; returns read data, ack latency in cycles from
  // the driving edge, and number of sampled cycles with busy high.
  task automatic xfer(input bit port, input logic we, input logic [5:0] a,
                      input logic [15:0] d, output logic [15:0] rd,
                      output int lat, output int busy_n);
    bit got = 0;
    rd = '0; lat = 0; busy_n = 0;
    @(negedge clk);
    if (port) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    else      begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (port ? ack1 : ack0) begin
        got = 1; lat = c; rd = port ? rdata1 : rdata0;
        req0 = 0; req1 = 0;
      end
    end
    if (!got) check("xfer_timeout", 0, 1);
    req0 = 0; req1 = 0;
  endtask

  // Both ports request in the same cycle; records ack timing and overlap.
  task automatic pair(input logic w0, input logic [5:0] a0, input logic [15:0] d0,
                      input logic w1, input logic [5:0] a1, input logic [15:0] d1,
                      output logic [15:0] r0, output logic [15:0] r1,
                      output int t0, output int t1, output int g1, output int ovl);
    r0 = '0; r1 = '0; t0 = 0; t1 = 0; g1 = 0; ovl = 0;
    @(negedge clk);
    req0 = 1; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = 1; we1 = w1; addr1 = a1; wdata1 = d1;
    for (int c = 1; c <= 20 && (t0 == 0 || t1 == 0); c++) begin
      @(negedge clk);
      if (c == 1) g1 = int'(gnt_id);
      if (ack0 && ack1) ovl++;
      if (ack0) begin t0 = c; r0 = rdata0; req0 = 0; end
      if (ack1) begin t1 = c; r1 = rdata1; req1 = 0; end
    end
    if (t0 == 0) check("pair_timeout0", 0, 1);
    if (t1 == 0) check("pair_timeout1", 0, 1);
    req0 = 0; req1 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd, r0, r1;
    int lat, bn, t0, t1, g1, ovl, n;
    int order [6];
    int times [6];

    repeat (2) @(negedge clk);
    rst = 0;

    // Reset with both requests asserted; memory must survive.
    xfer(0, 1, 6'd5, 16'h1234, rd, lat, bn);
    @(negedge clk);
    rst = 1;
    req0 = 1; we0 = 1; addr0 = 6'd5; wdata0 = 16'hDEAD;
    req1 = 1; we1 = 1; addr1 = 6'd5; wdata1 = 16'hDEAD;
    repeat (3) begin
      @(negedge clk);
      check("rst_ack0", ack0, 0);
      check("rst_ack1", ack1, 0);
      check("rst_busy", busy, 0);
      check("rst_rdata0", rdata0, 0);
      check("rst_rdata1", rdata1, 0);
    end
    check("rst_gnt_id", gnt_id, 0);
    req0 = 0; req1 = 0;
    @(negedge clk);
    rst = 0;
    xfer(1, 0, 6'd5, 16'h0, rd, lat, bn);
    check("rst_mem_kept", rd, 16'h1234);

    // Single port write then read.
    xfer(0, 1, 6'd10, 16'h3020, rd, lat, bn);
    check("wr_latency", lat, 2);
    check("wr_busy_cycles", bn, 1);
    check("wr_rdata0_unchanged", rdata0, 16'h0000);
    xfer(0, 0, 6'd10, 16'h0, rd, lat, bn);
    check("rd_latency", lat, 2);
    check("rd_busy_cycles", bn, 1);
    check("rd_data", rd, 16'h3020);
    @(negedge clk);
    check("rd_ack_pulse", ack0, 0);
    check("rd_data_held", rdata0, 16'h3020);
    xfer(0, 1, 6'd11, 16'h5555, rd, lat, bn);
    check("wr_keeps_rdata0", rdata0, 16'h3020);

    // Tie after reset: port 0 first, port 1 two cycles later.
    xfer(1, 1, 6'd20, 16'd9, rd, lat, bn);
    xfer(1, 1, 6'd21, 16'd4, rd, lat, bn);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    pair(0, 6'd20, 16'h0, 0, 6'd21, 16'h0, r0, r1, t0, t1, g1, ovl);
    check("tie_first_gnt", g1, 0);
    check("tie_t0", t0, 2);
    check("tie_t1", t1, 4);
    check("tie_rdata0", r0, 16'd9);
    check("tie_rdata1", r1, 16'd4);
    check("tie_overlap", ovl, 0);

    // Fairness: both ports hold req for six transactions.
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 6'd20;
    req1 = 1; we1 = 0; addr1 = 6'd21;
    n = 0; ovl = 0;
    for (int c = 1; c <= 40 && n < 6; c++) begin
      @(negedge clk);
      if (ack0 && ack1) ovl++;
      if (ack0 && n < 6) begin
        order[n] = 0; times[n] = c; n++;
        check("fair_rdata0", rdata0, 16'd9);
      end
      if (ack1 && n < 6) begin
        order[n] = 1; times[n] = c; n++;
        check("fair_rdata1", rdata1, 16'd4);
      end
    end
    req0 = 0; req1 = 0;
    if (n < 6) check("fair_timeout", n, 6);
    check("fair_overlap", ovl, 0);
    check("fair_first_time", times[0], 2);
    for (int i = 0; i < 6; i++) check("fair_order", order[i], i % 2);
    for (int i = 1; i < 6; i++) check("fair_spacing", times[i] - times[i-1], 2);

    // Reset during ACCESS aborts the write and the ack.
    xfer(0, 1, 6'd23, 16'h0000, rd, lat, bn);
    @(negedge clk);
    req1 = 1; we1 = 1; addr1 = 6'd23; wdata1 = 16'hBEEF;
    @(negedge clk);
    check("abort_in_access", busy, 1);
    rst = 1; req1 = 0;
    #1;
    check("abort_busy_cleared", busy, 0);
    repeat (2) begin
      @(negedge clk);
      check("abort_no_ack1", ack1, 0);
    end
    rst = 0;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_late_ack1", ack1, 0);
    end
    xfer(0, 0, 6'd23, 16'h0, rd, lat, bn);
    check("abort_mem_untouched", rd, 16'h0000);

    // Address boundaries 0 and 63, no aliasing.
    pair(1, 6'd0, 16'h0001, 1, 6'd63, 16'hFFFF, r0, r1, t0, t1, g1, ovl);
    check("bnd_wr_overlap", ovl, 0);
    pair(0, 6'd0, 16'h0, 0, 6'd63, 16'h0, r0, r1, t0, t1, g1, ovl);
    check("bnd_rdata0_addr0", r0, 16'h0001);
    check("bnd_rdata1_addr63", r1, 16'hFFFF);
    pair(0, 6'd63, 16'h0, 0, 6'd0, 16'h0, r0, r1, t0, t1, g1, ovl);
    check("bnd_rdata0_addr63", r0, 16'hFFFF);
    check("bnd_rdata1_addr0", r1, 16'h0001);
    check("bnd_rd_overlap", ovl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
